param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
Parametrised up/down counter and the successor to the team's 4-bit enable counter. It adds configurable width and modulo, synchronous load, and wrap or saturate mode. It also provides sticky overflow/underflow flags with a clear input and a one-cycle terminal-count pulse. It is used as a general event/timer counter in peripheral and test logic, driven by a single clock domain.

Parameters:
WIDTH, 4, counter bit width (>=2)
MAX_COUNT, 2**WIDTH-1, terminal (modulo) value; legal range 1..2**WIDTH-1; count range is 0..MAX_COUNT
PRESCALE_DIV, 4, enabled cycles per count step (>=1); used only when COUNTER_PRESCALE_EN is defined

Ports:
clk  input  1  clock; all state updates on posedge
reset_n  input  1  reset, asynchronous assert, active-low; release is synchronous to clk upstream
enable  input  1  count enable, active high
up_dn  input  1  direction: 1 = up, 0 = down
sat_mode  input  1  1 = saturate at boundary, 0 = wrap
load  input  1  synchronous load strobe, active high
load_value  input  WIDTH  value written on load
clear_flags  input  1  clears sticky flags, active high
counter_out  output  WIDTH  current count (registered)
overflow_out  output  1  sticky: an up-count event occurred at MAX_COUNT
underflow_out  output  1  sticky: a down-count event occurred at 0
tc_pulse  output  1  one-cycle pulse after any boundary event (overflow or underflow)

Behaviour:
- Reset (reset_n=0, async): counter_out=0, overflow_out=0, underflow_out=0, tc_pulse=0, prescaler=0. Holds while low.
- Priority per edge: load > count step > hold.
- load=1: counter_out <= min(load_value, MAX_COUNT), with clamping when the value is out of range. No flags set, tc_pulse=0, prescaler cleared. This applies regardless of enable.
- Count step occurs on an edge with enable=1, load=0 (and prescaler tick if the feature is enabled).
- Up, counter_out<MAX_COUNT: +1.
- Up, counter_out==MAX_COUNT: wrap to 0 (sat_mode=0) or hold MAX_COUNT (sat_mode=1). overflow_out<=1; tc_pulse<=1.
- Down, counter_out>0: -1.
- Down, counter_out==0: wrap to MAX_COUNT (sat_mode=0) or hold 0 (sat_mode=1). underflow_out<=1; tc_pulse<=1.
- Saturate mode: every enabled step at the boundary is a boundary event, so flags remain set and tc_pulse stays high each such cycle.
- Flags and tc_pulse update on the same edge as counter_out; latency is 1 cycle from the inputs to all outputs.
- tc_pulse is 0 on every edge without a boundary event.
- clear_flags=1: both sticky flags <= 0, unless a boundary event occurs on the same edge. In that case the flag for that event is set and the other is cleared (set wins).
- Direction and sat_mode may change on any cycle and take effect on the same edge.
- No internal modulo state beyond counter_out. A MAX_COUNT below 2**WIDTH-1 means values above MAX_COUNT are unreachable.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined: an internal prescaler counts enabled cycles 0..PRESCALE_DIV-1. A count step occurs only on the enabled edge where the prescaler equals PRESCALE_DIV-1; the prescaler then returns to 0. enable=0 freezes the prescaler. Load and reset clear it.
- Not defined: no prescaler logic; every enabled edge is a count step, and PRESCALE_DIV is ignored.

Decomposition:
- Package counter_pkg: direction constants (DIR_UP=1, DIR_DOWN=0), mode constants (MODE_WRAP=0, MODE_SAT=1), and a function computing the clamped load value.
- One sub-module, counter_prescaler (PRESCALE_DIV parameter; enable in, tick out, clear in), instantiated only under COUNTER_PRESCALE_EN.

Test Plan:
- WIDTH=4, MAX=9, up, wrap, enable 12 cycles from 0 -> counter 0..9,0,1,2; overflow_out=1 from the 10th edge; tc_pulse high exactly 1 cycle.
- Down, sat_mode=1, load 2 then enable 4 cycles -> 1,0,0,0; underflow_out=1; tc_pulse high on the last 2 edges.
- load_value=14 with MAX=9, with enable=1 -> counter=9, no flags set, tc_pulse=0.
- clear_flags=1 on the same edge as a wrap 9->0 with both flags previously set -> overflow_out=1, underflow_out=0.
- reset_n low mid-count (counter=5, flags set) between edges -> all outputs 0 immediately, without waiting for clk.
- COUNTER_PRESCALE_EN, PRESCALE_DIV=4, enable 12 cycles -> counter steps 0->3, one step every 4th edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings and helpers for param_updown_counter.
// Direction and mode enums match the raw up_dn / sat_mode port levels.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Load values above the terminal count are pulled back to it.
  function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                             input logic [63:0] max_count);
    return (value > max_count) ? max_count : value;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE_DIV; tick_o marks the enabled cycle that
// completes a group. clear_i resets the group count.
module counter_prescaler #(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate, sticky flags and a
// terminal-count pulse. Define COUNTER_PRESCALE_EN to insert a step prescaler.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned MAX_COUNT    = 2**WIDTH - 1,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             step;
  logic             at_max, at_zero;
  logic             ovf_ev, unf_ev;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_prescaler (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clear_i (load),
    .enable_i(enable && !load),
    .tick_o  (tick)
  );
`else
  // Every enabled edge steps; PRESCALE_DIV >= 1 makes this constant 1.
  assign tick = (PRESCALE_DIV != 0);
`endif

  assign step    = enable && !load && tick;
  assign at_max  = (cnt_q >= MAX_W);
  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (load) begin
      cnt_d = WIDTH'(clamp_load(64'(load_value), 64'(MAX_COUNT)));
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (at_max) begin
          ovf_ev = 1'b1;
          cnt_d  = (sat_mode == MODE_SAT) ? MAX_W : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          unf_ev = 1'b1;
          cnt_d  = (sat_mode == MODE_SAT) ? '0 : MAX_W;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // A boundary event on the same edge as clear_flags keeps its own flag set.
  always_comb begin
    ovf_d = (ovf_q && !clear_flags) || ovf_ev;
    unf_d = (unf_q && !clear_flags) || unf_ev;
    tc_d  = ovf_ev || unf_ev;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      tc_q  <= tc_d;
    end
  end

  assign counter_out   = cnt_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;
  assign tc_pulse      = tc_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomised and directed checks of param_updown_counter against a behavioural model.
module tb_param_updown_counter;

  localparam int W   = 4;
  localparam int MAX = 9;
  localparam int DIV = 4;
`ifdef COUNTER_PRESCALE_EN
  localparam int STEP_CYC = DIV;
`else
  localparam int STEP_CYC = 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable, up_dn, sat_mode, load, clear_flags;
  logic [W-1:0] load_value;
  logic [W-1:0] counter_out;
  logic         overflow_out, underflow_out, tc_pulse;

  int errors = 0;
  int checks = 0;

  int m_cnt, m_ps;
  bit m_ovf, m_unf, m_tc;
  int tc_seen, tc_model;

  always #5 clk = ~clk;

  param_updown_counter #(
    .WIDTH       (W),
    .MAX_COUNT   (MAX),
    .PRESCALE_DIV(DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .up_dn        (up_dn),
    .sat_mode     (sat_mode),
    .load         (load),
    .load_value   (load_value),
    .clear_flags  (clear_flags),
    .counter_out  (counter_out),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out),
    .tc_pulse     (tc_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ps = 0; m_ovf = 0; m_unf = 0; m_tc = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at that edge.
  task automatic model_edge();
    bit do_step, ovf_ev, unf_ev;
    ovf_ev = 0;
    unf_ev = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (load) begin
      m_cnt = (int'(load_value) > MAX) ? MAX : int'(load_value);
      m_ps  = 0;
    end else begin
      do_step = enable;
`ifdef COUNTER_PRESCALE_EN
      if (enable) begin
        if (m_ps == DIV - 1) m_ps = 0;
        else begin
          m_ps++;
          do_step = 0;
        end
      end
`endif
      if (do_step) begin
        if (up_dn) begin
          if (m_cnt == MAX) begin
            ovf_ev = 1;
            m_cnt  = sat_mode ? MAX : 0;
          end else m_cnt = (m_cnt + 1) % (MAX + 1);
        end else begin
          if (m_cnt == 0) begin
            unf_ev = 1;
            m_cnt  = sat_mode ? 0 : MAX;
          end else m_cnt = m_cnt - 1;
        end
      end
    end
    if (clear_flags) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (ovf_ev) m_ovf = 1;
    if (unf_ev) m_unf = 1;
    m_tc = ovf_ev | unf_ev;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cnt"}, 32'(counter_out), 32'(m_cnt));
    check({tag, ".ovf"}, 32'(overflow_out), 32'(m_ovf));
    check({tag, ".unf"}, 32'(underflow_out), 32'(m_unf));
    check({tag, ".tc"}, 32'(tc_pulse), 32'(m_tc));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input bit en, input bit up, input bit sat, input bit ld,
                        input logic [W-1:0] lv, input bit clr);
    enable = en; up_dn = up; sat_mode = sat; load = ld; load_value = lv; clear_flags = clr;
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, ".cnt"}, 32'(counter_out), 32'd0);
    check({tag, ".ovf"}, 32'(overflow_out), 32'd0);
    check({tag, ".unf"}, 32'(underflow_out), 32'd0);
    check({tag, ".tc"}, 32'(tc_pulse), 32'd0);
    model_reset();
    cycle({tag, "_hold"});
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, '0, 0);
    model_reset();
    #12;
    check("rst.cnt", 32'(counter_out), 32'd0);
    check("rst.flags", 32'({overflow_out, underflow_out, tc_pulse}), 32'd0);
    cycle("rst_hold");
    reset_n = 1'b1;

    // Up, wrap, 12 enabled edges from 0
    set_in(1, 1, 0, 0, '0, 0);
    tc_seen = 0;
    tc_model = 0;
    for (int i = 0; i < 12; i++) begin
      cycle("up_wrap");
      tc_seen += int'(tc_pulse);
      tc_model += int'(m_tc);
    end
    check("up_wrap_tc_count", 32'(tc_seen), 32'(tc_model));
`ifdef COUNTER_PRESCALE_EN
    check("presc_end", 32'(counter_out), 32'd3);
`else
    check("up_wrap_end", 32'(counter_out), 32'd2);
    check("up_wrap_ovf", 32'(overflow_out), 32'd1);
`endif

    // Down, saturate after loading 2
    set_in(0, 0, 1, 1, 4'd2, 0);
    cycle("dn_sat_load");
    set_in(1, 0, 1, 0, '0, 0);
    repeat (4 * STEP_CYC) cycle("dn_sat");

    // Out-of-range load clamps, with enable high
    set_in(1, 1, 0, 1, 4'd14, 0);
    cycle("clamp");
    check("clamp_val", 32'(counter_out), 32'd9);
    check("clamp_tc", 32'(tc_pulse), 32'd0);

    // Set both flags, then clear on the same edge as a 9->0 wrap
    set_in(0, 0, 0, 1, 4'd0, 0);
    cycle("both_load0");
    set_in(1, 0, 0, 0, '0, 0);
    repeat (STEP_CYC) cycle("both_unf");
    set_in(1, 1, 0, 0, '0, 0);
    repeat (STEP_CYC) cycle("both_ovf");
    set_in(0, 1, 0, 1, 4'd9, 0);
    cycle("both_load9");
    set_in(1, 1, 0, 0, '0, 1);
    repeat (STEP_CYC) cycle("clr_wrap");
    check("clr_wrap_ovf", 32'(overflow_out), 32'd1);
    check("clr_wrap_unf", 32'(underflow_out), 32'd0);

    // Async reset mid-count with a flag set
    set_in(0, 1, 0, 1, 4'd5, 0);
    cycle("pre_rst_load5");
    async_reset_check("async_rst");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 4) != 0, 1'($urandom), 1'($urandom), ($urandom % 16) == 0,
             W'($urandom), ($urandom % 10) == 0);
      cycle("rand");
      if (($urandom % 150) == 0) async_reset_check("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
